// File: rtl/cpu_pkg.sv
// Shared definitions for the execute datapath: opcode/condition encodings,
// flag bit positions, instruction field slices and the condition evaluator.
package cpu_pkg;

    localparam int CPU_DATA_W    = 32;
    localparam int CPU_MEM_DEPTH = 256;

    typedef enum logic [3:0] {
        OP_AND  = 4'h0,
        OP_EOR  = 4'h1,
        OP_SUB  = 4'h2,
        OP_ADD  = 4'h3,
        OP_ORR  = 4'h4,
        OP_MOVI = 4'h5,
        OP_MOV  = 4'h6,
        OP_MVN  = 4'h7,
        OP_LSL  = 4'h8,
        OP_LSR  = 4'h9,
        OP_ASR  = 4'hA,
        OP_ROR  = 4'hB,
        OP_CMP  = 4'hC,
        OP_TST  = 4'hD,
        OP_LDR  = 4'hE,
        OP_STR  = 4'hF
    } op_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'h0,
        CC_NE = 4'h1,
        CC_CS = 4'h2,
        CC_CC = 4'h3,
        CC_MI = 4'h4,
        CC_PL = 4'h5,
        CC_VS = 4'h6,
        CC_VC = 4'h7,
        CC_HI = 4'h8,
        CC_LS = 4'h9,
        CC_GE = 4'hA,
        CC_LT = 4'hB,
        CC_GT = 4'hC,
        CC_LE = 4'hD,
        CC_AL = 4'hE,
        CC_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int COND_HI  = 31;
    localparam int COND_LO  = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 24;
    localparam int S_BIT    = 23;
    localparam int RD_HI    = 22;
    localparam int RD_LO    = 19;
    localparam int RS2_HI   = 18;
    localparam int RS2_LO   = 15;
    localparam int RS1_HI   = 14;
    localparam int RS1_LO   = 11;
    localparam int IMM5_HI  = 10;
    localparam int IMM5_LO  = 6;
    localparam int IMM16_HI = 18;
    localparam int IMM16_LO = 3;

    function automatic logic cond_pass(input cond_e cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        pass = 1'b0;
        case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/cpu_exec_datapath_if.sv
// Instruction, preload and inspection bus of the execute datapath.
interface cpu_exec_datapath_if;

    logic [31:0] instr;
    logic        instr_valid;
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;
    logic [3:0]  dbg_sel;
    logic [31:0] dbg_reg;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [31:0] mem_rdata;

    modport master (
        output instr, instr_valid, load_en, load_addr, load_data, dbg_sel,
        input  dbg_reg, result, flags, mem_rdata
    );

    modport slave (
        input  instr, instr_valid, load_en, load_addr, load_data, dbg_sel,
        output dbg_reg, result, flags, mem_rdata
    );

endinterface

// File: rtl/cpu_exec_datapath_alu_core.sv
// Combinational ALU: produces the value and the would-be NZCV for every opcode.
// For LDR/STR the value is the wrapped 8-bit effective address.
module alu_core
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  imm5,
    input  op_e         op,
    input  logic [3:0]  flags_in,
    output logic [31:0] value,
    output logic [3:0]  nzcv_out
);

    logic [32:0] sum;
    logic [31:0] diff;
    logic [7:0]  addr;
    logic [4:0]  lsl_idx;
    logic        c_out;
    logic        v_out;

    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = a - b;
        addr    = a[7:0] + {3'b000, imm5};
        lsl_idx = 5'd0 - imm5;
        value   = '0;
        c_out   = flags_in[FLAG_C];
        v_out   = flags_in[FLAG_V];

        case (op)
            OP_AND, OP_TST: value = a & b;
            OP_EOR:         value = a ^ b;
            OP_ORR:         value = a | b;
            OP_MOVI:        value = b;
            OP_MOV:         value = a;
            OP_MVN:         value = ~a;
            OP_ADD: begin
                value = sum[31:0];
                c_out = sum[32];
                v_out = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            OP_SUB, OP_CMP: begin
                value = diff;
                c_out = (a >= b);
                v_out = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            // A zero shift amount leaves the operand untouched and keeps C.
            OP_LSL: begin
                value = a << imm5;
                if (imm5 != 5'd0) c_out = a[lsl_idx];
            end
            OP_LSR: begin
                value = a >> imm5;
                if (imm5 != 5'd0) c_out = a[imm5 - 5'd1];
            end
            OP_ASR: begin
                value = $unsigned($signed(a) >>> imm5);
                if (imm5 != 5'd0) c_out = a[imm5 - 5'd1];
            end
            OP_ROR: begin
                value = (a >> imm5) | (a << (6'd32 - {1'b0, imm5}));
                if (imm5 != 5'd0) c_out = a[imm5 - 5'd1];
            end
            OP_LDR, OP_STR: value = {24'h0, addr};
            default:        value = '0;
        endcase

        nzcv_out         = flags_in;
        nzcv_out[FLAG_N] = value[31];
        nzcv_out[FLAG_Z] = (value == 32'h0);
        nzcv_out[FLAG_C] = c_out;
        nzcv_out[FLAG_V] = v_out;
    end

endmodule

// File: rtl/cpu_exec_datapath.sv
// Single-issue execute stage: 16x32 register bank, NZCV flags, result register
// and a 256x32 data RAM with a bench preload port.
module cpu_exec_datapath
    import cpu_pkg::*;
#(
    parameter int DATA_W    = CPU_DATA_W,
    parameter int MEM_DEPTH = CPU_MEM_DEPTH
)
(
    input  logic               Clk,
    input  logic               Reset,
    cpu_exec_datapath_if.slave bus
);

    cond_e       cond;
    op_e         op;
    logic        s_bit;
    logic [3:0]  rd;
    logic [3:0]  rs2;
    logic [3:0]  rs1;
    logic [4:0]  imm5;
    logic [15:0] imm16;

    logic [DATA_W-1:0] regs_q [16];
    logic [DATA_W-1:0] regs_d [16];
    logic [3:0]        flags_q, flags_d;
    logic [31:0]       result_q, result_d;
    logic [31:0]       ram_q [MEM_DEPTH];

    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] b_in;
    logic [31:0] alu_value;
    logic [3:0]  alu_nzcv;
    logic [7:0]  mem_addr;
    logic [31:0] ram_rdata;
    logic        exec;
    logic        writes_rd;
    logic        sets_flags;
    logic        st_we;
    logic [31:0] exec_value;
    logic [3:0]  exec_nzcv;

    assign cond  = cond_e'(bus.instr[COND_HI:COND_LO]);
    assign op    = op_e'(bus.instr[OP_HI:OP_LO]);
    assign s_bit = bus.instr[S_BIT];
    assign rd    = bus.instr[RD_HI:RD_LO];
    assign rs2   = bus.instr[RS2_HI:RS2_LO];
    assign rs1   = bus.instr[RS1_HI:RS1_LO];
    assign imm5  = bus.instr[IMM5_HI:IMM5_LO];
    assign imm16 = bus.instr[IMM16_HI:IMM16_LO];

    assign rs1_val = regs_q[rs1];
    assign rs2_val = regs_q[rs2];
    assign b_in    = (op == OP_MOVI) ? {16'h0, imm16} : rs2_val;

    alu_core u_alu (
        .a        (rs1_val),
        .b        (b_in),
        .imm5     (imm5),
        .op       (op),
        .flags_in (flags_q),
        .value    (alu_value),
        .nzcv_out (alu_nzcv)
    );

    assign mem_addr  = alu_value[7:0];
    assign ram_rdata = ram_q[mem_addr];

    // Reset also gates the store so an edge caught inside reset cannot touch RAM.
    always_comb begin
        exec       = bus.instr_valid && cond_pass(cond, flags_q);
        writes_rd  = !(op inside {OP_CMP, OP_TST, OP_STR});
        sets_flags = s_bit || (op == OP_CMP) || (op == OP_TST);
        st_we      = exec && Reset && (op == OP_STR) &&
                     !(bus.load_en && (bus.load_addr == mem_addr));

        exec_value = alu_value;
        exec_nzcv  = alu_nzcv;
        if (op == OP_LDR) begin
            exec_value = ram_rdata;
            exec_nzcv  = {ram_rdata[31], (ram_rdata == 32'h0), alu_nzcv[FLAG_C], alu_nzcv[FLAG_V]};
        end

        regs_d   = regs_q;
        flags_d  = flags_q;
        result_d = result_q;
        if (exec) begin
            result_d = exec_value;
            if (writes_rd)  regs_d[rd] = exec_value;
            if (sets_flags) flags_d    = exec_nzcv;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            regs_q   <= '{default: '0};
            flags_q  <= '0;
            result_q <= '0;
        end else begin
            regs_q   <= regs_d;
            flags_q  <= flags_d;
            result_q <= result_d;
        end
    end

    // RAM is never reset; preload wins over a colliding store.
    always_ff @(posedge Clk) begin
        if (bus.load_en) ram_q[bus.load_addr] <= bus.load_data;
        if (st_we)       ram_q[mem_addr]      <= rs2_val;
    end

    assign bus.dbg_reg   = regs_q[bus.dbg_sel];
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;
    assign bus.mem_rdata = ram_q[bus.load_addr];

endmodule

// File: tb/tb_cpu_exec_datapath.sv
// Directed plus random checks of cpu_exec_datapath against an instruction-level model.
`timescale 1ns/1ps
module tb_cpu_exec_datapath;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    logic [31:0] m_reg [16];
    logic [31:0] m_ram [256];
    logic        m_n, m_z, m_c, m_v;
    logic [31:0] m_res;

    cpu_exec_datapath_if bus ();

    cpu_exec_datapath dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mkR(input logic [3:0] cond, input logic [3:0] op, input logic s,
                                        input logic [3:0] rd, input logic [3:0] rs2, input logic [3:0] rs1,
                                        input logic [4:0] imm5);
        return {cond, op, s, rd, rs2, rs1, imm5, 6'b0};
    endfunction

    function automatic logic [31:0] mkI(input logic [3:0] cond, input logic s, input logic [3:0] rd,
                                        input logic [15:0] imm16);
        return {cond, 4'h5, s, rd, imm16, 3'b0};
    endfunction

    function automatic logic condTrue(input logic [3:0] cond);
        case (cond)
            4'h0: return m_z;
            4'h1: return !m_z;
            4'h2: return m_c;
            4'h3: return !m_c;
            4'h4: return m_n;
            4'h5: return !m_n;
            4'h6: return m_v;
            4'h7: return !m_v;
            4'h8: return m_c && !m_z;
            4'h9: return !m_c || m_z;
            4'hA: return m_n == m_v;
            4'hB: return m_n != m_v;
            4'hC: return !m_z && (m_n == m_v);
            4'hD: return m_z || (m_n != m_v);
            4'hE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction-level reference: shifts are done one bit at a time,
    // arithmetic flags come from wide signed/unsigned sums.
    task automatic modelExec(input logic [31:0] ins, input logic v, input logic le,
                             input logic [7:0] la, input logic [31:0] ld);
        logic [3:0]  op, rd, rs2, rs1;
        logic [4:0]  imm5;
        logic        s;
        logic [31:0] a, b, val;
        logic [7:0]  addr;
        logic        nc, nv, wr, upd, st, arith_cv;
        longint      usum, sres;
        op   = ins[27:24];
        s    = ins[23];
        rd   = ins[22:19];
        rs2  = ins[18:15];
        rs1  = ins[14:11];
        imm5 = ins[10:6];
        a    = m_reg[rs1];
        b    = m_reg[rs2];
        addr = 8'((a + 32'(imm5)) % 32'd256);
        st   = 1'b0;
        if (v && condTrue(ins[31:28])) begin
            nc = m_c; nv = m_v; wr = 1'b1; upd = s; arith_cv = 1'b0;
            val = 32'h0;
            case (op)
                4'h0: val = a & b;
                4'h1: val = a ^ b;
                4'h4: val = a | b;
                4'h5: val = {16'h0, ins[18:3]};
                4'h6: val = a;
                4'h7: val = ~a;
                4'hD: begin val = a & b; wr = 1'b0; upd = 1'b1; end
                4'h3: begin
                    usum = longint'(a) + longint'(b);
                    val  = usum[31:0];
                    nc   = usum >= 64'h1_0000_0000;
                    sres = longint'($signed(a)) + longint'($signed(b));
                    arith_cv = 1'b1;
                end
                4'h2, 4'hC: begin
                    val  = a - b;
                    nc   = a >= b;
                    sres = longint'($signed(a)) - longint'($signed(b));
                    arith_cv = 1'b1;
                    if (op == 4'hC) begin wr = 1'b0; upd = 1'b1; end
                end
                4'h8: begin
                    val = a;
                    for (int i = 0; i < int'(imm5); i++) begin nc = val[31]; val = {val[30:0], 1'b0}; end
                end
                4'h9: begin
                    val = a;
                    for (int i = 0; i < int'(imm5); i++) begin nc = val[0]; val = {1'b0, val[31:1]}; end
                end
                4'hA: begin
                    val = a;
                    for (int i = 0; i < int'(imm5); i++) begin nc = val[0]; val = {val[31], val[31:1]}; end
                end
                4'hB: begin
                    val = a;
                    for (int i = 0; i < int'(imm5); i++) begin nc = val[0]; val = {val[0], val[31:1]}; end
                end
                4'hE: val = m_ram[addr];
                default: begin val = {24'h0, addr}; wr = 1'b0; st = 1'b1; end
            endcase
            if (arith_cv) nv = (sres > 64'sd2147483647) || (sres < -64'sd2147483648);
            if (upd) begin
                m_n = val[31];
                m_z = (val == 32'h0);
                m_c = nc;
                m_v = nv;
            end
            if (wr) m_reg[rd] = val;
            m_res = val;
        end
        if (st && !(le && la == addr)) m_ram[addr] = b;
        if (le) m_ram[la] = ld;
    endtask

    task automatic applyStimulus(input logic [31:0] ins, input logic v, input logic le,
                                 input logic [7:0] la, input logic [31:0] ld);
        @(negedge clk);
        bus.instr       = ins;
        bus.instr_valid = v;
        bus.load_en     = le;
        bus.load_addr   = la;
        bus.load_data   = ld;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.load_en     = 1'b0;
        modelExec(ins, v, le, la, ld);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkReg(input int idx, input logic [31:0] exp);
        bus.dbg_sel = 4'(idx);
        #1;
        checkOutput($sformatf("R%0d", idx), bus.dbg_reg, exp);
    endtask

    task automatic checkRam(input int addr, input logic [31:0] exp);
        bus.load_addr = 8'(addr);
        #1;
        checkOutput($sformatf("RAM[%0d]", addr), bus.mem_rdata, exp);
    endtask

    task automatic execAl(input logic [31:0] ins);
        applyStimulus(ins, 1'b1, 1'b0, 8'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ins;
        errors = 0;
        checks = 0;
        bus.instr = '0; bus.instr_valid = 1'b0; bus.load_en = 1'b0;
        bus.load_addr = '0; bus.load_data = '0; bus.dbg_sel = '0;
        for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_res = 32'h0;

        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1;
        checkOutput("reset_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("reset_result", bus.result, 32'h0);
        checkReg(0, 32'h0);
        checkReg(15, 32'h0);

        for (int i = 0; i < 256; i++) applyStimulus(32'h0, 1'b0, 1'b1, 8'(i), $urandom);

        execAl(mkI(4'hE, 1'b0, 4'd1, 16'd10));
        checkReg(1, 32'd10);
        checkOutput("movi_result", bus.result, 32'd10);
        checkOutput("movi_flags", {28'h0, bus.flags}, 32'h0);

        execAl(mkI(4'hE, 1'b0, 4'd2, 16'd10));
        execAl(mkR(4'hE, 4'hC, 1'b0, 4'd0, 4'd2, 4'd1, 5'd0));
        checkOutput("cmp_flags", {28'h0, bus.flags}, 32'h6);
        checkOutput("cmp_result", bus.result, 32'h0);
        execAl(mkR(4'h1, 4'h3, 1'b0, 4'd3, 4'd2, 4'd1, 5'd0));
        checkReg(3, 32'h0);
        checkOutput("ne_skip_result", bus.result, 32'h0);
        execAl(mkR(4'h0, 4'h3, 1'b0, 4'd3, 4'd2, 4'd1, 5'd0));
        checkReg(3, 32'd20);
        checkOutput("eq_add_flags_held", {28'h0, bus.flags}, 32'h6);

        execAl(mkI(4'hE, 1'b0, 4'd1, 16'h7FFF));
        execAl(mkR(4'hE, 4'h8, 1'b0, 4'd1, 4'd0, 4'd1, 5'd16));
        execAl(mkI(4'hE, 1'b0, 4'd4, 16'hFFFF));
        execAl(mkR(4'hE, 4'h4, 1'b0, 4'd1, 4'd4, 4'd1, 5'd0));
        checkReg(1, 32'h7FFF_FFFF);
        execAl(mkI(4'hE, 1'b0, 4'd2, 16'd1));
        execAl(mkR(4'hE, 4'h3, 1'b1, 4'd6, 4'd2, 4'd1, 5'd0));
        checkOutput("adds_result", bus.result, 32'h8000_0000);
        checkOutput("adds_flags", {28'h0, bus.flags}, 32'h9);
        execAl(mkI(4'hE, 1'b0, 4'd0, 16'd0));
        execAl(mkR(4'hE, 4'h2, 1'b1, 4'd7, 4'd2, 4'd0, 5'd0));
        checkReg(7, 32'hFFFF_FFFF);
        checkOutput("subs_flags", {28'h0, bus.flags}, 32'h8);

        execAl(mkI(4'hE, 1'b0, 4'd1, 16'd1));
        execAl(mkI(4'hE, 1'b0, 4'd4, 16'h8000));
        execAl(mkR(4'hE, 4'h8, 1'b0, 4'd4, 4'd0, 4'd4, 5'd16));
        execAl(mkR(4'hE, 4'h4, 1'b0, 4'd1, 4'd4, 4'd1, 5'd0));
        execAl(mkR(4'hE, 4'h8, 1'b1, 4'd8, 4'd0, 4'd1, 5'd1));
        checkReg(8, 32'h0000_0002);
        checkOutput("lsls_flags", {28'h0, bus.flags}, 32'h2);
        execAl(mkR(4'hE, 4'hB, 1'b1, 4'd10, 4'd0, 4'd1, 5'd0));
        checkReg(10, 32'h8000_0001);
        checkOutput("ror0_flags", {28'h0, bus.flags}, 32'hA);
        execAl(mkR(4'hE, 4'hA, 1'b1, 4'd9, 4'd0, 4'd1, 5'd4));
        checkReg(9, 32'hF800_0000);
        checkOutput("asrs_flags", {28'h0, bus.flags}, 32'h8);

        execAl(mkI(4'hE, 1'b0, 4'd1, 16'd250));
        execAl(mkI(4'hE, 1'b0, 4'd2, 16'hDEAD));
        execAl(mkR(4'hE, 4'hF, 1'b0, 4'd0, 4'd2, 4'd1, 5'd10));
        checkOutput("str_result", bus.result, 32'd4);
        checkRam(4, 32'h0000_DEAD);
        execAl(mkR(4'hE, 4'hE, 1'b0, 4'd5, 4'd0, 4'd1, 5'd10));
        checkReg(5, 32'h0000_DEAD);
        checkOutput("ldr_result", bus.result, 32'h0000_DEAD);

        // Reset lands in the middle of a valid ADD: state clears without waiting for a clock.
        @(negedge clk);
        bus.instr       = mkR(4'hE, 4'h3, 1'b1, 4'd11, 4'd2, 4'd1, 5'd0);
        bus.instr_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_flags", {28'h0, bus.flags}, 32'h0);
        checkOutput("rst_result", bus.result, 32'h0);
        checkReg(1, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.instr_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_reg[i] = 32'h0;
        {m_n, m_z, m_c, m_v} = 4'b0000;
        m_res = 32'h0;
        checkReg(5, 32'h0);
        checkReg(11, 32'h0);
        checkRam(4, 32'h0000_DEAD);

        execAl(mkI(4'hE, 1'b0, 4'd2, 16'hBEEF));
        applyStimulus(mkR(4'hE, 4'hF, 1'b0, 4'd0, 4'd2, 4'd1, 5'd4), 1'b1, 1'b1, 8'd4, 32'h0000_1234);
        checkRam(4, 32'h0000_1234);
        applyStimulus(mkR(4'hE, 4'hF, 1'b0, 4'd0, 4'd2, 4'd1, 5'd5), 1'b1, 1'b1, 8'd6, 32'h0000_5678);
        checkRam(5, 32'h0000_BEEF);
        checkRam(6, 32'h0000_5678);

        for (int k = 0; k < 300; k++) begin
            ins = $urandom;
            if ($urandom_range(1, 0) == 1) ins[31:28] = 4'hE;
            applyStimulus(ins, ($urandom_range(7, 0) != 0), ($urandom_range(9, 0) == 0),
                          8'($urandom), $urandom);
            checkOutput($sformatf("rand%0d_result", k), bus.result, m_res);
            checkOutput($sformatf("rand%0d_flags", k), {28'h0, bus.flags}, {28'h0, m_n, m_z, m_c, m_v});
            if (k % 10 == 9) for (int r = 0; r < 16; r++) checkReg(r, m_reg[r]);
        end
        for (int r = 0; r < 16; r++) checkReg(r, m_reg[r]);
        for (int a = 0; a < 256; a++) checkRam(a, m_ram[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
